// File: rtl/dmem_arbiter.sv
// Two-requester arbiter serialising single-word accesses to one data memory (IDLE -> ACCESS -> IDLE).
// Fixed priority with a starvation guard by default; define DMEM_ARB_RR_EN for round-robin ties.
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  logic [0:0]        state_q, state_d;
  logic              sel_q, sel_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic              m0_gnt_q, m0_gnt_d;
  logic              m1_gnt_q, m1_gnt_d;
  logic              m0_rvalid_q, m0_rvalid_d;
  logic              m1_rvalid_q, m1_rvalid_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
  logic              tie;
  logic              win1;

`ifdef DMEM_ARB_RR_EN
  logic              last_winner_q, last_winner_d;
`else
  localparam int WAIT_W = ($clog2(MAX_WAIT + 1) > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    address_d    = address_q;
    write_data_d = write_data_q;
    m0_gnt_d     = 1'b0;
    m1_gnt_d     = 1'b0;
    m0_rvalid_d  = 1'b0;
    m1_rvalid_d  = 1'b0;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    tie          = m0_req & m1_req;
`ifdef DMEM_ARB_RR_EN
    last_winner_d = last_winner_q;
    win1          = tie ? ~last_winner_q : m1_req;
`else
    wait_cnt_d    = wait_cnt_q;
    win1          = tie ? (wait_cnt_q == WAIT_MAX) : m1_req;
`endif

    case (state_q)
      IDLE: begin
        if (m0_req | m1_req) begin
          state_d = ACCESS;
          sel_d   = win1;
          // Only the winner's fields reach the memory, so junk on the loser cannot leak.
          if (win1) begin
            m1_gnt_d     = 1'b1;
            mem_read_d   = ~m1_we;
            mem_write_d  = m1_we;
            address_d    = m1_addr;
            write_data_d = m1_wdata;
          end else begin
            m0_gnt_d     = 1'b1;
            mem_read_d   = ~m0_we;
            mem_write_d  = m0_we;
            address_d    = m0_addr;
            write_data_d = m0_wdata;
          end
`ifdef DMEM_ARB_RR_EN
          last_winner_d = win1;
`else
          if (win1) begin
            wait_cnt_d = '0;
          end else if (tie && (wait_cnt_q != WAIT_MAX)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
        if (mem_read_q) begin
          if (sel_q) begin
            m1_rdata_d  = read_data;
            m1_rvalid_d = 1'b1;
          end else begin
            m0_rdata_d  = read_data;
            m0_rvalid_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      sel_q        <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      address_q    <= '0;
      write_data_q <= '0;
      m0_gnt_q     <= 1'b0;
      m1_gnt_q     <= 1'b0;
      m0_rvalid_q  <= 1'b0;
      m1_rvalid_q  <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
`ifdef DMEM_ARB_RR_EN
      last_winner_q <= 1'b1;
`else
      wait_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      address_q    <= address_d;
      write_data_q <= write_data_d;
      m0_gnt_q     <= m0_gnt_d;
      m1_gnt_q     <= m1_gnt_d;
      m0_rvalid_q  <= m0_rvalid_d;
      m1_rvalid_q  <= m1_rvalid_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
`ifdef DMEM_ARB_RR_EN
      last_winner_q <= last_winner_d;
`else
      wait_cnt_q    <= wait_cnt_d;
`endif
    end
  end

  assign m0_gnt     = m0_gnt_q;
  assign m1_gnt     = m1_gnt_q;
  assign m0_rvalid  = m0_rvalid_q;
  assign m1_rvalid  = m1_rvalid_q;
  assign m0_rdata   = m0_rdata_q;
  assign m1_rdata   = m1_rdata_q;
  assign MemRead    = mem_read_q;
  assign MemWrite   = mem_write_q;
  assign address    = address_q;
  assign write_data = write_data_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
// A 16-word memory model stands in for data_memory; expected values come from the model only.
module tb_dmem_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        MemRead, MemWrite;
  logic [31:0] address, write_data, read_data;

  int n_chk = 0;
  int n_err = 0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .MemRead(MemRead), .MemWrite(MemWrite), .address(address),
    .write_data(write_data), .read_data(read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return 32'h1000_0000 + i * 32'h0011_0101;
  endfunction

  // Memory stand-in: unreset, writes commit at the edge ending the MemWrite cycle.
  logic [31:0] mem [16];
  logic        mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (MemWrite) begin
      mem[address[3:0]] <= write_data;
    end
  end
  assign read_data = MemRead ? mem[address[3:0]] : 32'hDEAD_BEEF;

  // Reference model state: expected outputs for the current cycle plus arbitration history.
  logic [31:0] ref_mem [16];
  bit          e_gnt0, e_gnt1, e_rv0, e_rv1, e_rd, e_wr;
  logic [31:0] e_addr, e_wdata, e_rd0, e_rd1;
  int          starve;
  bit          last_w;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit w1, tie;
    if (e_wr) ref_mem[e_addr[3:0]] = e_wdata;
    if (reset) begin
      e_gnt0 = 0; e_gnt1 = 0; e_rv0 = 0; e_rv1 = 0; e_rd = 0; e_wr = 0;
      e_addr = '0; e_wdata = '0; e_rd0 = '0; e_rd1 = '0;
      starve = 0; last_w = 1'b1;
    end else if (e_gnt0 || e_gnt1) begin
      e_rv0 = e_rd && e_gnt0;
      e_rv1 = e_rd && e_gnt1;
      if (e_rv0) e_rd0 = ref_mem[e_addr[3:0]];
      if (e_rv1) e_rd1 = ref_mem[e_addr[3:0]];
      e_gnt0 = 0; e_gnt1 = 0; e_rd = 0; e_wr = 0;
    end else begin
      e_rv0 = 0; e_rv1 = 0;
      tie = m0_req && m1_req;
      if (m0_req || m1_req) begin
`ifdef DMEM_ARB_RR_EN
        w1 = tie ? !last_w : m1_req;
        last_w = w1;
`else
        w1 = tie ? (starve >= MAX_WAIT) : m1_req;
        if (w1) starve = 0;
        else if (tie && starve < MAX_WAIT) starve++;
`endif
        e_gnt0  = !w1;
        e_gnt1  = w1;
        e_wr    = w1 ? m1_we : m0_we;
        e_rd    = !e_wr;
        e_addr  = w1 ? m1_addr : m0_addr;
        e_wdata = w1 ? m1_wdata : m0_wdata;
      end
    end
  endtask

  task automatic check_all();
    check_eq("m0_gnt", m0_gnt, e_gnt0);
    check_eq("m1_gnt", m1_gnt, e_gnt1);
    check_eq("gnt_excl", m0_gnt & m1_gnt, 0);
    check_eq("m0_rvalid", m0_rvalid, e_rv0);
    check_eq("m1_rvalid", m1_rvalid, e_rv1);
    check_eq("MemRead", MemRead, e_rd);
    check_eq("MemWrite", MemWrite, e_wr);
    check_eq("address", address, e_addr);
    check_eq("write_data", write_data, e_wdata);
    check_eq("m0_rdata", m0_rdata, e_rd0);
    check_eq("m1_rdata", m1_rdata, e_rd1);
  endtask

  // Inputs set by the caller apply to the current cycle; outputs of the next cycle are checked.
  task automatic tick();
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic set_req(input int p, input bit r, input bit we, input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      m0_req = r; m0_we = we; m0_addr = a; m0_wdata = d;
    end else begin
      m1_req = r; m1_we = we; m1_addr = a; m1_wdata = d;
    end
  endtask

  function automatic bit gnt_of(input int p);
    return (p == 0) ? m0_gnt : m1_gnt;
  endfunction

  function automatic bit rvalid_of(input int p);
    return (p == 0) ? m0_rvalid : m1_rvalid;
  endfunction

  // One isolated access from an idle arbiter: gnt one cycle after req, rvalid one cycle later.
  task automatic access(input int p, input bit we, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int n_rd);
    int n;
    n = 0;
    n_rd = 0;
    set_req(p, 1'b1, we, a, d);
    do begin
      tick();
      n++;
      if (MemRead) n_rd++;
    end while (!gnt_of(p) && n < 16);
    check_eq("acc_gnt_latency", n, 1);
    check_eq("acc_address", address, a);
    check_eq("acc_rw", {MemWrite, MemRead}, we ? 2'b10 : 2'b01);
    set_req(p, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    if (MemRead) n_rd++;
    check_eq("acc_rvalid", rvalid_of(p), {31'b0, !we});
    rd = (p == 0) ? m0_rdata : m1_rdata;
  endtask

  task automatic drive_random(input int p);
    bit g, r;
    g = gnt_of(p);
    r = (p == 0) ? m0_req : m1_req;
    if (g || !r) begin
      if ($urandom_range(0, 1) == 1)
        set_req(p, 1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom);
      else
        set_req(p, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    int          n_rd;
    int          n_g;
    int          who;
    int          exp_who;

    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    e_gnt0 = 0; e_gnt1 = 0; e_rv0 = 0; e_rv1 = 0; e_rd = 0; e_wr = 0;
    e_addr = '0; e_wdata = '0; e_rd0 = '0; e_rd1 = '0; starve = 0; last_w = 1'b1;

    // Reset with both requesters asserting.
    reset = 1'b1;
    set_req(0, 1'b1, 1'b0, 32'd1, 32'h0);
    set_req(1, 1'b1, 1'b1, 32'd2, 32'h0);
    tick();
    tick();
    check_eq("rst_gnt", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}, 0);
    check_eq("rst_mem", {MemRead, MemWrite}, 0);
    check_eq("rst_addr", address, 0);
    reset = 1'b0;
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // m0 write then m1 read-back of the same word.
    access(0, 1'b1, 32'd7, 32'h16CD_EFFF, rd, n_rd);
    access(1, 1'b0, 32'd7, 32'h0, rd, n_rd);
    check_eq("wr_rd_back", rd, 32'h16CD_EFFF);

    // m0 read with m1 idle.
    access(0, 1'b0, 32'd2, 32'h0, rd, n_rd);
    check_eq("rd2_data", rd, init_word(2));
    check_eq("rd2_memread_cycles", n_rd, 1);
    check_eq("rd2_m1_rvalid", m1_rvalid, 0);

    // Both requesters held continuously, reads only, from a fresh reset.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_req(0, 1'b1, 1'b0, 32'd4, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'd5, 32'h0);
    n_g = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (m0_gnt || m1_gnt) begin
        who = m1_gnt ? 1 : 0;
`ifdef DMEM_ARB_RR_EN
        exp_who = n_g % 2;
`else
        exp_who = (n_g % (MAX_WAIT + 1) == MAX_WAIT) ? 1 : 0;
`endif
        check_eq("tie_order", who, exp_who);
        n_g++;
      end
    end
    check_eq("tie_grant_count", n_g, 10);

    // m1 write interrupted by reset during its access cycle.
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_req(1, 1'b1, 1'b1, 32'd3, 32'hA5A5_A5A5);
    tick();
    check_eq("rstacc_gnt", m1_gnt, 1);
    reset = 1'b1;
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check_eq("rstacc_after", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}, 0);
    reset = 1'b0;
    tick();
    access(0, 1'b0, 32'd3, 32'h0, rd, n_rd);
    check_eq("rstacc_commit", rd, 32'hA5A5_A5A5);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      drive_random(0);
      drive_random(1);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
